// File: rtl/pm_dm_memory_v2.sv
// ---------------------------------------------------------------------------
// pm_dm_memory_v2
//   Program/data memory for the processor core.
//   - PM: synchronous read port plus a write port driven by the sequencer.
//   - DM: write address is taken at the request edge and the data lands one
//     edge later. A read of the address being written forwards bc_dt.
//   - After reset a hardware sequencer zeroes every DM word. mem_rdy goes
//     high once the whole array has been cleared.
//
// Ports
//   clk         system clock, rising edge
//   reset       asynchronous, active-high reset
//   ps_pm_cslt  PM chip select
//   ps_pm_wrb   PM direction (1 = write, 0 = read)
//   ps_pm_add   PM address
//   ps_pm_dt    PM write data
//   pm_ps_op    PM read data (registered)
//   ps_dm_cslt  DM chip select
//   ps_dm_wrb   DM direction (1 = write, 0 = read)
//   dg_dm_add   DM address from the DAG
//   bc_dt       DM write data, valid the cycle after the write request
//   dm_bc_dt    DM read data (registered)
//   mem_rdy     DM clear finished, DM accepts accesses
//
// PM_LOCATE names the simulation image for PM. The synthesizable body does
// not load it; PM contents come from the write port or the memory flow.
// ---------------------------------------------------------------------------
module pm_dm_memory_v2 #(
    parameter int PMA_SIZE  = 16,
    parameter int PMD_SIZE  = 32,
    parameter int DMA_SIZE  = 17,
    parameter int DMD_SIZE  = 16,
    parameter     PM_LOCATE = "pm_file.txt",
    parameter bit DM_CLR    = 1'b1
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                ps_pm_cslt,
    input  logic                ps_pm_wrb,
    input  logic [PMA_SIZE-1:0] ps_pm_add,
    input  logic [PMD_SIZE-1:0] ps_pm_dt,
    output logic [PMD_SIZE-1:0] pm_ps_op,
    input  logic                ps_dm_cslt,
    input  logic                ps_dm_wrb,
    input  logic [DMA_SIZE-1:0] dg_dm_add,
    input  logic [DMD_SIZE-1:0] bc_dt,
    output logic [DMD_SIZE-1:0] dm_bc_dt,
    output logic                mem_rdy
);

    localparam int PM_DEPTH = 2 ** PMA_SIZE;
    localparam int DM_DEPTH = 2 ** DMA_SIZE;
    localparam logic [DMA_SIZE-1:0] CLR_LAST = {DMA_SIZE{1'b1}};
    localparam logic [DMA_SIZE-1:0] CLR_ONE  = {{(DMA_SIZE-1){1'b0}}, 1'b1};

    typedef enum logic [0:0] {
        ST_CLEAR = 1'b0,
        ST_READY = 1'b1
    } state_t;

    logic [PMD_SIZE-1:0] pm_mem [PM_DEPTH];
    logic [DMD_SIZE-1:0] dm_mem [DM_DEPTH];

    state_t              state_r;
    logic [DMA_SIZE-1:0] clr_cnt_r;
    logic                wp_vld_r;
    logic [DMA_SIZE-1:0] wp_add_r;

    logic                pm_wr_s;
    logic                pm_rd_s;
    logic                dm_wr_req_s;
    logic                dm_rd_req_s;
    logic                byp_hit_s;
    logic                dm_we_s;
    logic [DMA_SIZE-1:0] dm_wa_s;
    logic [DMD_SIZE-1:0] dm_wd_s;

    // Decode PM/DM requests and the forwarding hit.
    always_comb begin
        pm_wr_s     = ps_pm_cslt & ps_pm_wrb;
        pm_rd_s     = ps_pm_cslt & ~ps_pm_wrb;
        dm_wr_req_s = ps_dm_cslt & ps_dm_wrb;
        dm_rd_req_s = ps_dm_cslt & ~ps_dm_wrb;
        // Forwarding needs a live pending write; a leftover wp_add_r is ignored.
        byp_hit_s   = wp_vld_r & (wp_add_r == dg_dm_add);
    end

    // Single DM write port, shared by the clear sequencer and the deferred write.
    always_comb begin
        dm_we_s = 1'b0;
        dm_wa_s = {DMA_SIZE{1'b0}};
        dm_wd_s = {DMD_SIZE{1'b0}};
        if (reset) begin
            dm_we_s = 1'b0;
        end else if (state_r == ST_CLEAR) begin
            dm_we_s = 1'b1;
            dm_wa_s = clr_cnt_r;
            dm_wd_s = {DMD_SIZE{1'b0}};
        end else if (wp_vld_r) begin
            dm_we_s = 1'b1;
            dm_wa_s = wp_add_r;
            dm_wd_s = bc_dt;
        end else begin
            dm_we_s = 1'b0;
        end
    end

    // PM array write port. The array is not reset.
    always_ff @(posedge clk) begin
        if (pm_wr_s && !reset) begin
            pm_mem[ps_pm_add] <= ps_pm_dt;
        end
    end

    // DM array write port. The array is not reset; the clear sequence zeroes it.
    always_ff @(posedge clk) begin
        if (dm_we_s) begin
            dm_mem[dm_wa_s] <= dm_wd_s;
        end
    end

    // Control state, PM read register and DM read/pending-write registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r   <= DM_CLR ? ST_CLEAR : ST_READY;
            clr_cnt_r <= {DMA_SIZE{1'b0}};
            wp_vld_r  <= 1'b0;
            wp_add_r  <= {DMA_SIZE{1'b0}};
            pm_ps_op  <= {PMD_SIZE{1'b0}};
            dm_bc_dt  <= {DMD_SIZE{1'b0}};
            mem_rdy   <= 1'b0;
        end else begin
            // PM is usable in both states.
            if (pm_rd_s) begin
                pm_ps_op <= pm_mem[ps_pm_add];
            end

            case (state_r)
                ST_CLEAR: begin
                    // DM requests are dropped while the array is being zeroed.
                    wp_vld_r <= 1'b0;
                    if (clr_cnt_r == CLR_LAST) begin
                        state_r <= ST_READY;
                        mem_rdy <= 1'b1;
                    end else begin
                        clr_cnt_r <= clr_cnt_r + CLR_ONE;
                    end
                end
                ST_READY: begin
                    mem_rdy  <= 1'b1;
                    wp_vld_r <= dm_wr_req_s;
                    if (dm_wr_req_s) begin
                        wp_add_r <= dg_dm_add;
                    end
                    // Array read sees the pre-commit value; a same-address
                    // pending write is covered by forwarding bc_dt.
                    if (dm_rd_req_s) begin
                        dm_bc_dt <= byp_hit_s ? bc_dt : dm_mem[dg_dm_add];
                    end
                end
                default: begin
                    state_r  <= ST_CLEAR;
                    wp_vld_r <= 1'b0;
                    mem_rdy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_pm_dm_memory_v2.sv
module tb_pm_dm_memory_v2;

    localparam int PA = 4;
    localparam int PD = 32;
    localparam int DA = 4;
    localparam int DD = 16;
    localparam int DM_WORDS = 16;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          ps_pm_cslt = 1'b0;
    logic          ps_pm_wrb = 1'b0;
    logic [PA-1:0] ps_pm_add = '0;
    logic [PD-1:0] ps_pm_dt = '0;
    logic [PD-1:0] pm_ps_op;
    logic          ps_dm_cslt = 1'b0;
    logic          ps_dm_wrb = 1'b0;
    logic [DA-1:0] dg_dm_add = '0;
    logic [DD-1:0] bc_dt = '0;
    logic [DD-1:0] dm_bc_dt;
    logic          mem_rdy;

    int n_checks = 0;
    int n_fail = 0;
    bit chk_on = 1'b0;

    pm_dm_memory_v2 #(
        .PMA_SIZE(PA), .PMD_SIZE(PD), .DMA_SIZE(DA), .DMD_SIZE(DD),
        .PM_LOCATE("pm_file.txt"), .DM_CLR(1'b1)
    ) dut (
        .clk(clk), .reset(reset),
        .ps_pm_cslt(ps_pm_cslt), .ps_pm_wrb(ps_pm_wrb),
        .ps_pm_add(ps_pm_add), .ps_pm_dt(ps_pm_dt), .pm_ps_op(pm_ps_op),
        .ps_dm_cslt(ps_dm_cslt), .ps_dm_wrb(ps_dm_wrb),
        .dg_dm_add(dg_dm_add), .bc_dt(bc_dt), .dm_bc_dt(dm_bc_dt),
        .mem_rdy(mem_rdy)
    );

    always #5 clk = ~clk;

    // ---------------- behavioural model ----------------
    // DM is treated as all-zero from reset on: nothing can observe or write
    // it until the clear has run for DM_WORDS edges.
    logic [PD-1:0] pm_m [16];
    logic [DD-1:0] dm_m [DM_WORDS];
    logic [PD-1:0] exp_pm;
    logic [DD-1:0] exp_dm;
    logic          exp_rdy;
    int            edges_since_rel;
    bit            pend_vld;
    logic [DA-1:0] pend_add;

    task automatic model_step();
        bit ready;
        if (reset) begin
            exp_pm = '0; exp_dm = '0; exp_rdy = 1'b0;
            edges_since_rel = 0; pend_vld = 1'b0;
            for (int i = 0; i < DM_WORDS; i++) dm_m[i] = '0;
        end else begin
            ready = (edges_since_rel >= DM_WORDS);
            if (ps_pm_cslt) begin
                if (ps_pm_wrb) pm_m[ps_pm_add] = ps_pm_dt;
                else           exp_pm = pm_m[ps_pm_add];
            end
            if (ready) begin
                if (ps_dm_cslt && !ps_dm_wrb)
                    exp_dm = (pend_vld && pend_add == dg_dm_add) ? bc_dt : dm_m[dg_dm_add];
                if (pend_vld) dm_m[pend_add] = bc_dt;
                pend_vld = ps_dm_cslt && ps_dm_wrb;
                pend_add = dg_dm_add;
            end
            if (edges_since_rel < 1000) edges_since_rel++;
            exp_rdy = (edges_since_rel >= DM_WORDS);
        end
    endtask

    initial begin
        forever begin
            @(posedge clk or posedge reset);
            model_step();
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Every-cycle comparison against the model.
    initial begin
        forever begin
            @(negedge clk);
            if (chk_on) begin
                chk("model_pm_ps_op", pm_ps_op, exp_pm);
                chk("model_dm_bc_dt", {16'h0000, dm_bc_dt}, {16'h0000, exp_dm});
                chk("model_mem_rdy", {31'd0, mem_rdy}, {31'd0, exp_rdy});
            end
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic cyc(input logic pcs, input logic pwr, input logic [PA-1:0] pa,
                       input logic [PD-1:0] pd, input logic dcs, input logic dwr,
                       input logic [DA-1:0] da, input logic [DD-1:0] bd);
        ps_pm_cslt = pcs; ps_pm_wrb = pwr; ps_pm_add = pa; ps_pm_dt = pd;
        ps_dm_cslt = dcs; ps_dm_wrb = dwr; dg_dm_add = da; bc_dt = bd;
        @(negedge clk);
    endtask

    task automatic idle(input logic [DD-1:0] bd);
        cyc(1'b0, 1'b0, 4'd0, 32'd0, 1'b0, 1'b0, 4'd0, bd);
    endtask

    task automatic dm_wr(input logic [DA-1:0] a, input logic [DD-1:0] bd);
        cyc(1'b0, 1'b0, 4'd0, 32'd0, 1'b1, 1'b1, a, bd);
    endtask

    task automatic dm_rd(input logic [DA-1:0] a, input logic [DD-1:0] bd);
        cyc(1'b0, 1'b0, 4'd0, 32'd0, 1'b1, 1'b0, a, bd);
    endtask

    task automatic wait_ready();
        int n;
        n = 0;
        while (!mem_rdy && n < 40) begin
            idle(16'h0000);
            n++;
        end
        chk("ready_timeout", {31'd0, mem_rdy}, 32'd1);
    endtask

    task automatic pulse_reset_checked(input string tag);
        #2 reset = 1'b1;
        #1;
        chk({tag, "_async_pm"}, pm_ps_op, 32'd0);
        chk({tag, "_async_dm"}, {16'h0000, dm_bc_dt}, 32'd0);
        chk({tag, "_async_rdy"}, {31'd0, mem_rdy}, 32'd0);
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
    endtask

    // ---------------- directed test sequence ----------------
    initial begin
        @(negedge clk);
        chk_on = 1'b1;
        @(negedge clk);
        reset = 1'b0;

        // Clear sequence: mem_rdy low for exactly 16 cycles; DM read in CLEAR ignored.
        for (int k = 1; k <= 16; k++) begin
            if (k == 3) dm_rd(4'd0, 16'h7777);
            else        idle(16'h0000);
            chk("clear_rdy", {31'd0, mem_rdy}, (k == 16) ? 32'd1 : 32'd0);
        end
        chk("clear_dm_ignored", {16'h0000, dm_bc_dt}, 32'd0);

        // Preload DM[5] = 1234 and confirm it.
        dm_wr(4'd5, 16'h0000);
        idle(16'h1234);
        dm_rd(4'd5, 16'h0000);
        chk("preload_5", {16'h0000, dm_bc_dt}, 32'h0000_1234);

        // Reset again; PM and DM behaviour during CLEAR.
        pulse_reset_checked("rst1");
        cyc(1'b1, 1'b1, 4'd3, 32'hDEADBEEF, 1'b0, 1'b0, 4'd0, 16'h0000);
        cyc(1'b1, 1'b0, 4'd3, 32'h0000_0000, 1'b1, 1'b0, 4'd5, 16'h5555);
        chk("pm_rd_in_clear", pm_ps_op, 32'hDEADBEEF);
        chk("dm_rd_in_clear", {16'h0000, dm_bc_dt}, 32'd0);
        wait_ready();
        dm_rd(4'd5, 16'hAAAA);
        chk("cleared_5", {16'h0000, dm_bc_dt}, 32'd0);

        // Deferred write: request N, data N+1, read N+3.
        dm_wr(4'd10, 16'h0000);
        idle(16'hFFEE);
        idle(16'h0000);
        dm_rd(4'd10, 16'h0000);
        chk("deferred_10", {16'h0000, dm_bc_dt}, 32'h0000_FFEE);

        // Bypass, then no stale forward.
        dm_wr(4'd15, 16'h0000);
        dm_rd(4'd15, 16'hA5A5);
        chk("bypass_15", {16'h0000, dm_bc_dt}, 32'h0000_A5A5);
        idle(16'h0000);
        dm_rd(4'd15, 16'h0001);
        chk("no_stale_15", {16'h0000, dm_bc_dt}, 32'h0000_A5A5);

        // Back-to-back writes.
        dm_wr(4'd1, 16'h0000);
        dm_wr(4'd2, 16'h0011);
        dm_wr(4'd3, 16'h0022);
        idle(16'h0033);
        dm_rd(4'd1, 16'h0000);
        chk("b2b_1", {16'h0000, dm_bc_dt}, 32'h0000_0011);
        dm_rd(4'd2, 16'h0000);
        chk("b2b_2", {16'h0000, dm_bc_dt}, 32'h0000_0022);
        dm_rd(4'd3, 16'h0000);
        chk("b2b_3", {16'h0000, dm_bc_dt}, 32'h0000_0033);

        // Read different address while a write is pending; write still commits.
        dm_wr(4'd9, 16'h0000);
        dm_rd(4'd10, 16'h4321);
        chk("pend_other_rd", {16'h0000, dm_bc_dt}, 32'h0000_FFEE);
        dm_rd(4'd9, 16'h0000);
        chk("pend_other_commit", {16'h0000, dm_bc_dt}, 32'h0000_4321);

        // Reset between write request and data commit.
        cyc(1'b1, 1'b0, 4'd3, 32'd0, 1'b0, 1'b0, 4'd0, 16'h0000);
        dm_wr(4'd7, 16'h0000);
        bc_dt = 16'hBEEF;
        ps_dm_cslt = 1'b0;
        pulse_reset_checked("rst2");
        wait_ready();
        dm_rd(4'd7, 16'h0000);
        chk("reset_drop_7", {16'h0000, dm_bc_dt}, 32'd0);
        idle(16'h0000);

        chk_on = 1'b0;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
